fb_channel_serializer: RTL and testbench
========================================

# fb_channel_serializer

Output scheduler for the parallel 16-channel non-uniform filter bank (`total_filter`). On each new filter-bank sample it snapshots all channel outputs and streams the software-enabled channels, lowest index first, over a single valid/ready word stream tagged with channel index. It sits between `total_filter.filter_out` and the downstream sink (FIFO or host interface). It also flags any sample that arrives before the previous frame has drained.

## Interface

Parameters:
- `NCH`, 16: number of filter-bank channels.
- `DW`, 33: channel word width, signed sfix33 (matches `filter_out`).
- `CW`, 4: channel index width, $clog2(NCH).

Ports:
- `clock`  in  1: single clock for the block.
- `reset`  in  1: synchronous, active-high.
- `sample_strobe`  in  1: one-cycle pulse; `filter_out` holds a new valid sample this cycle (wrapper drives it as `clk_enable` delayed one cycle).
- `filter_out`  in  NCH x DW signed: parallel filter-bank outputs, array [NCH-1:0].
- `chan_mask`  in  NCH: bit i=1 enables channel i; sampled only at snapshot.
- `out_data`  out  DW signed: current channel word.
- `out_chan`  out  CW: index of `out_data`.
- `out_valid`  out  1: word available.
- `out_ready`  in  1: sink accepts; handshake = `out_valid & out_ready`.
- `out_last`  out  1: current word is the last enabled channel of the frame.
- `busy`  out  1: frame in progress (state SEND).
- `overrun`  out  1: one-cycle pulse when a strobe is dropped.
- `overrun_cnt`  out  16: saturating count of dropped strobes (macro only).

## Operation

- States: IDLE, SEND.
- IDLE, `sample_strobe`=1:
  - Latch all NCH words into a snapshot register.
  - Latch `rem_mask` <= `chan_mask`.
  - If `chan_mask` != 0, go to SEND; else stay IDLE (empty frame, no output, no overrun).
- SEND:
  - `out_chan` = lowest set bit of `rem_mask`.
  - `out_data` = snapshot[`out_chan`].
  - `out_last` = (`rem_mask` has exactly one bit set).
- Handshake in SEND: clear that bit of `rem_mask`. If it was the last bit, go to IDLE.
- Without a handshake, `out_data`, `out_chan`, `out_last` and `out_valid` hold stable. `out_valid` never drops before the handshake.
- `sample_strobe` in SEND, not coinciding with the final handshake:
  - Strobe is dropped. Snapshot and `rem_mask` are untouched.
  - `overrun` pulses the next cycle.
- `sample_strobe` on the same cycle as the final handshake (`out_last` accepted): treated as the IDLE case. New snapshot, no overrun, seamless next frame.
- `chan_mask` changes mid-frame have no effect until the next snapshot.
- `out_valid` = `busy` = (state==SEND).
- Arithmetic: data is passed through unmodified, with no rounding or resizing.

## Timing

- Reset values, cycle after reset asserted:
  - state IDLE; `rem_mask` 0.
  - `out_valid`, `out_last`, `busy`, `overrun` = 0.
  - `out_chan` 0; `out_data` 0; `overrun_cnt` 0.
- Reset mid-frame aborts the frame. Partially sent words are not replayed.
- Latency: strobe accepted at edge N, so `out_valid`=1 with the first enabled channel after edge N (visible cycle N+1).
- Throughput: one word per cycle while `out_ready` stays high. A frame of k enabled channels takes k cycles.
- A new frame can start with zero bubble when the strobe coincides with the final handshake.
- `overrun` is registered and lasts exactly one cycle per dropped strobe.

## Configuration

- Macro: `FB_SER_OVERRUN_CNT_EN`.
- Defined:
  - `overrun_cnt` port and a 16-bit counter are present.
  - The counter increments on each dropped strobe and saturates at 16'hFFFF.
  - It clears only on `reset`.
- Undefined:
  - Port and counter are absent.
  - The `overrun` pulse is still generated.

## Structure

- Shared package `fb_pkg`:
  - `FB_NCH`=16, `FB_DW`=33.
  - `typedef logic signed [FB_DW-1:0] fb_word_t`.
  - `typedef logic [$clog2(FB_NCH)-1:0] fb_chan_t`.
  - State enum `fb_ser_state_e` {IDLE, SEND}.
- Sub-module `fb_lowest_set`: combinational NCH-bit priority encoder. Outputs index of the lowest set bit, `any`, and `onehot_only` (exactly one bit set). It is used for `out_chan` and `out_last`.

## Test plan

- Full mask with `out_ready`=1:
  - Stimulus: `chan_mask`=16'hFFFF, strobe with `filter_out[i]`=i*1000−5000.
  - Required response: 16 consecutive words, `out_chan` 0..15, matching data, `out_last` only on chan 15, `busy` low at the cycle after.
- Sparse mask with backpressure:
  - Stimulus: `chan_mask`=16'h8421, `out_ready` toggling 1010….
  - Required response: channels 0, 5, 10, 15 in order; data/chan stable while stalled; `out_last` with chan 15.
- Overrun:
  - Stimulus: mask 16'hFFFF, `out_ready`=0, second strobe 3 cycles later.
  - Required response: `overrun` single pulse; `overrun_cnt`=1 (macro defined); frame data still from the first snapshot.
- Seamless next frame:
  - Stimulus: strobe on the same cycle as the final handshake of a mask=16'h0003 frame.
  - Required response: no overrun; next cycle `out_chan`=0 carries the new snapshot.
- Empty mask:
  - Stimulus: `chan_mask`=0, strobe.
  - Required response: `out_valid` stays 0, `busy` 0, no `overrun`.
- Reset mid-frame:
  - Stimulus: assert `reset` after 4 of 16 words, then strobe.
  - Required response: all outputs reach reset values the cycle after reset; the following strobe starts a fresh frame at chan 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the filter-bank output path.
package fb_pkg;

    localparam int FB_NCH = 16;
    localparam int FB_DW  = 33;

    typedef logic signed [FB_DW-1:0]         fb_word_t;
    typedef logic [$clog2(FB_NCH)-1:0]       fb_chan_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } fb_ser_state_e;

endpackage

// File: rtl/fb_lowest_set.sv
// Combinational priority encoder: index of the lowest set bit, plus
// "any bit set" and "exactly one bit set" flags.
module fb_lowest_set
    import fb_pkg::*;
#(
    parameter int N = FB_NCH,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any,
    output logic         onehot_only
);

    // Scanning downward leaves the lowest set bit as the final assignment.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
    end

    assign any         = |vec;
    assign onehot_only = any & ~(|(vec & (vec - N'(1))));

endmodule

// File: rtl/fb_channel_serializer.sv
// Snapshots the 16 filter-bank outputs on each sample strobe and streams the
// enabled channels lowest-first. Optional macro FB_SER_OVERRUN_CNT_EN adds a
// saturating dropped-strobe counter port.
module fb_channel_serializer
    import fb_pkg::*;
#(
    parameter int NCH = FB_NCH,
    parameter int DW  = FB_DW,
    parameter int CW  = $clog2(NCH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sample_strobe,
    input  logic signed [DW-1:0] filter_out [NCH-1:0],
    input  logic [NCH-1:0]       chan_mask,
    output logic signed [DW-1:0] out_data,
    output logic [CW-1:0]        out_chan,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 overrun
`ifdef FB_SER_OVERRUN_CNT_EN
    ,
    output logic [15:0]          overrun_cnt
`endif
);

    fb_ser_state_e        state, state_next;
    logic signed [DW-1:0] snap [NCH-1:0];
    logic [NCH-1:0]       rem_mask;
    logic [CW-1:0]        low_idx;
    logic                 rem_any;
    logic                 rem_last;
    logic                 handshake;
    logic                 final_hs;
    logic                 take;
    logic                 drop;

    fb_lowest_set #(.N(NCH), .W(CW)) u_lowest (
        .vec         (rem_mask),
        .idx         (low_idx),
        .any         (rem_any),
        .onehot_only (rem_last)
    );

    // A strobe landing on the final handshake starts the next frame directly.
    assign handshake = out_valid & out_ready;
    assign final_hs  = handshake & rem_last;
    assign take      = sample_strobe & ((state == IDLE) | final_hs);
    assign drop      = sample_strobe & (state == SEND) & ~final_hs;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (take && chan_mask != '0) state_next = SEND;
            SEND: if (final_hs) state_next = (take && chan_mask != '0) ? SEND : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == SEND);
        out_valid = busy & rem_any;
        out_last  = busy & rem_last;
        out_chan  = busy ? low_idx : '0;
        out_data  = busy ? snap[low_idx] : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rem_mask <= '0;
            overrun  <= 1'b0;
            for (int i = 0; i < NCH; i++) snap[i] <= '0;
        end else begin
            overrun <= drop;
            if (take) begin
                snap     <= filter_out;
                rem_mask <= chan_mask;
            end else if (handshake) begin
                rem_mask[low_idx] <= 1'b0;
            end
        end
    end

`ifdef FB_SER_OVERRUN_CNT_EN
    always_ff @(posedge clock) begin
        if (reset)                          overrun_cnt <= '0;
        else if (drop && overrun_cnt != '1) overrun_cnt <= overrun_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fb_channel_serializer.sv
// Randomized + directed bench for fb_channel_serializer against a queue-based
// frame model.
module tb_fb_channel_serializer;

    localparam int NCH = 16;
    localparam int DW  = 33;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 sample_strobe = 1'b0;
    logic signed [DW-1:0] filter_out [NCH-1:0];
    logic signed [DW-1:0] fo_next    [NCH-1:0];
    logic [NCH-1:0]       chan_mask = '0;
    logic signed [DW-1:0] out_data;
    logic [3:0]           out_chan;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic                 out_last;
    logic                 busy;
    logic                 overrun;
`ifdef FB_SER_OVERRUN_CNT_EN
    logic [15:0]          overrun_cnt;
`endif

    fb_channel_serializer dut (
        .clock         (clock),
        .reset         (reset),
        .sample_strobe (sample_strobe),
        .filter_out    (filter_out),
        .chan_mask     (chan_mask),
        .out_data      (out_data),
        .out_chan      (out_chan),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .busy          (busy),
        .overrun       (overrun)
`ifdef FB_SER_OVERRUN_CNT_EN
        ,
        .overrun_cnt   (overrun_cnt)
`endif
    );

    always #5 clock = ~clock;

    // Model: the words still owed for the current frame, in send order.
    int                   q_chan [$];
    logic signed [DW-1:0] q_data [$];
    logic                 exp_ovr = 1'b0;
    int                   exp_cnt = 0;
    logic                 rst_chk = 1'b1;
    int                   n_cmp = 0;
    int                   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("valid",   64'(out_valid), 64'(q_chan.size() != 0));
        chk("busy",    64'(busy),      64'(q_chan.size() != 0));
        chk("last",    64'(out_last),  64'(q_chan.size() == 1));
        chk("overrun", 64'(overrun),   64'(exp_ovr));
        if (q_chan.size() != 0) begin
            chk("chan", 64'(out_chan), 64'(q_chan[0]));
            chk("data", out_data, q_data[0]);
        end
        if (rst_chk) begin
            chk("rst_chan", 64'(out_chan), 64'd0);
            chk("rst_data", out_data, 64'd0);
        end
`ifdef FB_SER_OVERRUN_CNT_EN
        chk("ovr_cnt", 64'(overrun_cnt), 64'(exp_cnt));
`endif
    endtask

    task automatic model_step();
        bit was_idle, hs, fin;
        if (reset) begin
            q_chan.delete();
            q_data.delete();
            exp_ovr = 1'b0;
            exp_cnt = 0;
            rst_chk = 1'b1;
            return;
        end
        rst_chk  = 1'b0;
        was_idle = (q_chan.size() == 0);
        hs       = !was_idle && out_ready;
        fin      = hs && q_chan.size() == 1;
        exp_ovr  = 1'b0;
        if (hs) begin
            void'(q_chan.pop_front());
            void'(q_data.pop_front());
        end
        if (sample_strobe) begin
            if (was_idle || fin) begin
                for (int i = 0; i < NCH; i++) begin
                    if (chan_mask[i]) begin
                        q_chan.push_back(i);
                        q_data.push_back(filter_out[i]);
                    end
                end
            end else begin
                exp_ovr = 1'b1;
                if (exp_cnt < 65535) exp_cnt++;
            end
        end
    endtask

    // One clock: check current outputs, drive next inputs, advance the model.
    task automatic cycle(input bit s, input logic [NCH-1:0] m, input bit r, input bit rs);
        @(negedge clock);
        check_outputs();
        sample_strobe = s;
        chan_mask     = m;
        out_ready     = r;
        reset         = rs;
        filter_out    = fo_next;
        model_step();
    endtask

    task automatic rand_data();
        for (int i = 0; i < NCH; i++) fo_next[i] = DW'({$urandom(), $urandom()});
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) begin
            fo_next[i]    = '0;
            filter_out[i] = '0;
        end

        cycle(0, '0, 0, 1);
        cycle(0, '0, 0, 0);

        // Full mask, ready held high
        for (int i = 0; i < NCH; i++) fo_next[i] = DW'(i * 1000 - 5000);
        cycle(1, 16'hFFFF, 1, 0);
        rand_data();
        for (int i = 0; i < 18; i++) cycle(0, 16'hFFFF, 1, 0);

        // Sparse mask, ready toggling
        rand_data();
        cycle(1, 16'h8421, 1, 0);
        rand_data();
        for (int i = 0; i < 10; i++) cycle(0, 16'h0000, (i % 2) == 0, 0);

        // Overrun: second strobe while stalled
        rand_data();
        cycle(1, 16'hFFFF, 0, 0);
        rand_data();
        cycle(0, 16'hFFFF, 0, 0);
        cycle(0, 16'hFFFF, 0, 0);
        cycle(1, 16'hFFFF, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 16'hFFFF, 0, 0);
        for (int i = 0; i < 18; i++) cycle(0, 16'hFFFF, 1, 0);

        // Seamless next frame on final handshake
        rand_data();
        cycle(1, 16'h0003, 1, 0);
        cycle(0, 16'h0003, 1, 0);
        rand_data();
        cycle(1, 16'h0003, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 16'h0003, 1, 0);

        // Empty mask
        rand_data();
        cycle(1, 16'h0000, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 16'h0000, 1, 0);

        // Reset after 4 words, then a fresh frame
        rand_data();
        cycle(1, 16'hFFFF, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 16'hFFFF, 1, 0);
        cycle(0, 16'hFFFF, 1, 1);
        rand_data();
        cycle(1, 16'hFFFF, 1, 0);
        for (int i = 0; i < 18; i++) cycle(0, 16'hFFFF, 1, 0);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            logic [NCH-1:0] m;
            int sel;
            rand_data();
            sel = $urandom_range(0, 9);
            m = (sel == 0) ? '0 : (sel == 1) ? '1 : NCH'($urandom());
            cycle($urandom_range(0, 7) == 0, m, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 599) == 0);
        end
        cycle(0, '0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
